// File: rtl/uart_mmio.sv
// Memory-mapped 8N1 UART for the RV32i data bus. The bus timing matches dmem:
// writes take effect on the clock edge, and read data is registered one cycle later.
// Word map: 0 TXDATA, 1 RXDATA, 2 STATUS, 3 CTRL.
module uart_mmio #(
    parameter int unsigned CLKS_PER_BIT = 217
) (
    input  logic        clk_i,
    input  logic        resetn_i,
    input  logic        cs_i,
    input  logic        we_i,
    input  logic        re_i,
    input  logic [3:0]  ble_i,
    input  logic [1:0]  add_i,
    input  logic [31:0] d_i,
    output logic [31:0] d_o,
    input  logic        rx_i,
    output logic        tx_o,
    output logic        irq_o
);

    localparam logic [15:0] BIT_LAST = 16'(CLKS_PER_BIT - 1);
    localparam logic [15:0] BIT_HALF = 16'(CLKS_PER_BIT / 2);

    typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

    // bus decode
    logic wr, rd, tx_load, rx_read, st_wr, ctrl_wr;
    logic tx_busy, tx_ie, rx_valid, overrun, frame_err;
    logic [7:0] rx_byte;

    assign wr      = cs_i & we_i;
    assign rd      = cs_i & re_i;
    assign tx_load = wr & (add_i == 2'd0) & ble_i[0] & ~tx_busy;
    assign rx_read = rd & (add_i == 2'd1);
    assign st_wr   = wr & (add_i == 2'd2) & ble_i[0];
    assign ctrl_wr = wr & (add_i == 2'd3) & ble_i[0];

    // upper write-data bits and lanes have no register behind them
    logic unused_bus;
    assign unused_bus = ^{d_i[31:8], ble_i[3:1]};

    // ---------------- transmitter ----------------
    state_t      tx_state;
    logic [15:0] tx_cnt;
    logic [2:0]  tx_bit;
    logic [7:0]  tx_shift;

    // TX FSM: every state lasts CLKS_PER_BIT cycles; tx_o is a register so the line never glitches
    always_ff @(posedge clk_i or negedge resetn_i) begin
        if (!resetn_i) begin
            tx_state <= S_IDLE;
            tx_cnt   <= '0;
            tx_bit   <= '0;
            tx_shift <= '0;
            tx_o     <= 1'b1;
            tx_busy  <= 1'b0;
        end else begin
            case (tx_state)
                S_IDLE: begin
                    if (tx_load) begin
                        tx_shift <= d_i[7:0];
                        tx_busy  <= 1'b1;
                        tx_o     <= 1'b0;
                        tx_cnt   <= BIT_LAST;
                        tx_state <= S_START;
                    end
                end
                S_START: begin
                    if (tx_cnt == 16'd0) begin
                        tx_o     <= tx_shift[0];
                        tx_cnt   <= BIT_LAST;
                        tx_bit   <= 3'd0;
                        tx_state <= S_DATA;
                    end else begin
                        tx_cnt <= tx_cnt - 16'd1;
                    end
                end
                S_DATA: begin
                    if (tx_cnt == 16'd0) begin
                        tx_cnt <= BIT_LAST;
                        if (tx_bit == 3'd7) begin
                            tx_o     <= 1'b1;
                            tx_state <= S_STOP;
                        end else begin
                            tx_shift <= {1'b0, tx_shift[7:1]};
                            tx_o     <= tx_shift[1];
                            tx_bit   <= tx_bit + 3'd1;
                        end
                    end else begin
                        tx_cnt <= tx_cnt - 16'd1;
                    end
                end
                default: begin
                    if (tx_cnt == 16'd0) begin
                        tx_busy  <= 1'b0;
                        tx_state <= S_IDLE;
                    end else begin
                        tx_cnt <= tx_cnt - 16'd1;
                    end
                end
            endcase
        end
    end

    // ---------------- receiver ----------------
    logic        rx_s1, rx_s2;
    state_t      rx_state;
    logic [15:0] rx_cnt;
    logic [2:0]  rx_bit;
    logic [7:0]  rx_shift;
    logic        rx_stop_hit;

    // two-flop synchronizer for the asynchronous serial input; idles high
    always_ff @(posedge clk_i or negedge resetn_i) begin
        if (!resetn_i) begin
            rx_s1 <= 1'b1;
            rx_s2 <= 1'b1;
        end else begin
            rx_s1 <= rx_i;
            rx_s2 <= rx_s1;
        end
    end

    // RX FSM: half-bit delay after the falling edge, then one sample per bit at mid-bit
    always_ff @(posedge clk_i or negedge resetn_i) begin
        if (!resetn_i) begin
            rx_state <= S_IDLE;
            rx_cnt   <= '0;
            rx_bit   <= '0;
            rx_shift <= '0;
        end else begin
            case (rx_state)
                S_IDLE: begin
                    if (!rx_s2) begin
                        rx_cnt   <= BIT_HALF;
                        rx_state <= S_START;
                    end
                end
                S_START: begin
                    if (rx_cnt == 16'd0) begin
                        if (!rx_s2) begin
                            rx_cnt   <= BIT_LAST;
                            rx_bit   <= 3'd0;
                            rx_state <= S_DATA;
                        end else begin
                            rx_state <= S_IDLE;   // glitch, not a start bit
                        end
                    end else begin
                        rx_cnt <= rx_cnt - 16'd1;
                    end
                end
                S_DATA: begin
                    if (rx_cnt == 16'd0) begin
                        rx_shift <= {rx_s2, rx_shift[7:1]};
                        rx_cnt   <= BIT_LAST;
                        if (rx_bit == 3'd7) rx_state <= S_STOP;
                        else                rx_bit   <= rx_bit + 3'd1;
                    end else begin
                        rx_cnt <= rx_cnt - 16'd1;
                    end
                end
                default: begin
                    // leave at the mid-stop sample so a back-to-back start bit is caught
                    if (rx_cnt == 16'd0) rx_state <= S_IDLE;
                    else                 rx_cnt   <= rx_cnt - 16'd1;
                end
            endcase
        end
    end

    assign rx_stop_hit = (rx_state == S_STOP) && (rx_cnt == 16'd0);

    // ---------------- flags and control ----------------
    // later assignments win, so a hardware event beats a same-edge firmware clear
    always_ff @(posedge clk_i or negedge resetn_i) begin
        if (!resetn_i) begin
            rx_valid  <= 1'b0;
            rx_byte   <= '0;
            overrun   <= 1'b0;
            frame_err <= 1'b0;
            tx_ie     <= 1'b0;
        end else begin
            if (rx_read) rx_valid <= 1'b0;
            if (st_wr && d_i[2]) overrun   <= 1'b0;
            if (st_wr && d_i[3]) frame_err <= 1'b0;
            if (ctrl_wr) tx_ie <= d_i[0];
            if (rx_stop_hit) begin
                if (rx_s2) begin
                    if (!rx_valid || rx_read) begin
                        rx_byte  <= rx_shift;
                        rx_valid <= 1'b1;
                    end else begin
                        overrun <= 1'b1;
                    end
                end else begin
                    frame_err <= 1'b1;
                end
            end
        end
    end

    // registered read port; holds its value on cycles without a read strobe
    always_ff @(posedge clk_i or negedge resetn_i) begin
        if (!resetn_i) begin
            d_o <= '0;
        end else if (rd) begin
            case (add_i)
                2'd1:    d_o <= {rx_valid, 23'b0, rx_byte};
                2'd2:    d_o <= {28'b0, frame_err, overrun, rx_valid, tx_busy};
                2'd3:    d_o <= {31'b0, tx_ie};
                default: d_o <= '0;
            endcase
        end
    end

    assign irq_o = rx_valid | (~tx_busy & tx_ie);

endmodule

// File: doc/uart_mmio.md
Name: uart_mmio

Overview:
- Memory-mapped 8N1 UART peripheral on the RV32i SoC data bus, in parallel with dmem.
- The SoC address decoder drives its chip select; its read data feeds the data-out multiplexer alongside dmem.
- Bus protocol matches the synchronous data memory: writes take effect on the clock edge, and read data is registered with 1-cycle latency.
- Gives firmware a console: transmit holding register, receive register, and status/error flags.

Parameters:
- CLKS_PER_BIT, 217, clock cycles per UART bit (217 = 115200 baud at 25 MHz); legal range 4..65535.

Ports:
- clk_i  in  1  system clock
- resetn_i  in  1  reset, asynchronous, active-low
- cs_i  in  1  chip select from SoC address decoder
- we_i  in  1  write strobe, valid only with cs_i
- re_i  in  1  read strobe, valid only with cs_i
- ble_i  in  4  byte lane enables for writes
- add_i  in  2  word index (byte address bits [3:2])
- d_i  in  32  write data
- d_o  out  32  registered read data
- rx_i  in  1  serial input (asynchronous)
- tx_o  out  1  serial output
- irq_o  out  1  high while rx_valid=1 or tx_busy=0 with tx_ie=1

Behaviour:
- Reset (asynchronous, resetn_i=0):
  - tx_o=1, d_o=0, irq_o=0.
  - All flags clear, tx_ie=0.
  - Both FSMs go to IDLE and counters clear.
  - Reset mid-frame aborts it immediately; tx_o returns to 1.
- Register map, by add_i:
  - 0 TXDATA (write-only, reads 0).
    - A write with ble_i[0]=1 while tx_busy=0 loads d_i[7:0] and sets tx_busy on the same edge.
    - A write while busy is silently dropped.
  - 1 RXDATA (read-only).
    - Read returns {rx_valid, 23'b0, rx_byte}.
    - The read clears rx_valid at the same edge that captures d_o.
  - 2 STATUS.
    - Read returns {28'b0, frame_err, overrun, rx_valid, tx_busy}.
    - Writing 1 to bit2/bit3 (ble_i[0]=1) clears overrun/frame_err; writing 0 has no effect.
  - 3 CTRL (read/write): bit0 = tx_ie; all other bits read 0.
- Read path:
  - d_o updates only on an edge where cs_i&re_i; otherwise it holds its value.
  - Value is sampled pre-edge, so the RXDATA read returns valid=1 and the flag clears afterwards.
- Simultaneous strobes: cs_i&we_i&re_i in the same cycle performs both; the read returns pre-write contents.
- TX FSM, states IDLE -> START -> DATA -> STOP -> IDLE:
  - Each state lasts CLKS_PER_BIT cycles; tx_o driven from a register.
  - START drives 0; DATA shifts 8 bits LSB first; STOP drives 1.
  - tx_busy is 1 from the load edge until the end of STOP, for a total frame of 10*CLKS_PER_BIT cycles.
  - A TXDATA write in the same cycle tx_busy falls is dropped, because busy is sampled pre-edge.
- RX path:
  - rx_i passes through a 2-flop synchronizer; the synchronized value goes to the FSM.
  - IDLE: a synchronized 0 enters START and loads the counter to CLKS_PER_BIT/2 (integer division).
  - START: at mid-bit, if the line is still 0 go to DATA; otherwise treat it as a glitch and return to IDLE.
  - DATA: sample 8 bits, one every CLKS_PER_BIT cycles, at mid-bit, LSB first.
  - STOP: sample at mid-bit.
    - If 1: deliver the byte.
    - If 0: set frame_err, discard the byte, leave rx_valid unchanged.
  - After STOP, return to IDLE immediately at the mid-bit sample (ready for back-to-back frames).
- Byte delivery:
  - If rx_valid=0: rx_byte=new byte, rx_valid=1.
  - If rx_valid=1 and no RXDATA read on this edge: keep the old byte and set overrun.
  - If an RXDATA read happens on the same edge: the new byte replaces the old, rx_valid stays 1, no overrun.
- irq_o is combinational from the flag registers.

Test Plan (CLKS_PER_BIT=8):
- Write 0x55 to TXDATA:
  - tx_o = 0 for 8 cycles, then bits 1,0,1,0,1,0,1,0 (8 cycles each), then 1.
  - tx_busy=1 for exactly 80 cycles.
  - A second write of 0xFF during the frame is ignored, so no second frame follows.
- Drive rx_i with frame 0xA3, then read RXDATA:
  - d_o=0x800000A3 one cycle after the read strobe.
  - An immediate re-read returns 0x000000A3.
- Receive 0x11 then 0x22 without reading:
  - RXDATA reads 0x80000011 and STATUS bit2=1.
  - Write STATUS 0x4: bit2 clears.
- Frame 0x3C with stop bit driven 0:
  - rx_valid stays 0 and frame_err=1.
  - A 3-cycle low glitch on an idle rx_i produces no byte and no error.
- Assert resetn_i mid-TX at bit 4:
  - tx_o=1 and tx_busy=0 asynchronously.
  - After release, writing 0x0F transmits a clean complete frame.
- CTRL=1 with the TX idle: irq_o=1; it drops during transmission and rises at the end of STOP.
